pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have parameter W, default 32, giving the width of the counters and measurement outputs.
REQ-002 i_clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  Reset, asynchronous and active-low; it SHALL force every register to its reset value.
REQ-004 i_pwm  input  1  PWM waveform to measure; it SHALL be treated as asynchronous to i_clk.
REQ-005 i_timeout  input  W  Stuck-line limit in i_clk cycles; 0 SHALL disable the stuck-line detection.
REQ-006 i_ack  input  1  Consumer acknowledge; it SHALL clear o_valid.
REQ-007 i_clr  input  1  SHALL clear o_overrun.
REQ-008 o_period  output  W  SHALL give the measured period in i_clk cycles, rising edge to rising edge.
REQ-009 o_high  output  W  SHALL give the measured high time in i_clk cycles, rising edge to falling edge.
REQ-010 o_valid  output  1  SHALL be high while an unacknowledged measurement is held.
REQ-011 o_overrun  output  1  Sticky flag; SHALL indicate a measurement was overwritten before it was acknowledged.
REQ-012 o_stuck  output  1  SHALL indicate that no edge arrived within i_timeout cycles.
REQ-013 o_level  output  1  SHALL give the synchronized line level, valid while o_stuck=1.

Function
REQ-014 i_pwm SHALL pass through a 2-flop synchronizer, followed by a previous-value flop that provides edge detection.
- Rising edge = sync=1 and prev=0.
- Falling edge = sync=0 and prev=1.
REQ-015 The FSM SHALL have four states: ARM, HIGH, LOW, STUCK.
- Reset state is ARM.
REQ-016 ARM SHALL ignore falling edges and SHALL move to HIGH on a rising edge, without producing a measurement.
REQ-017 Edge counter behaviour, shared by all states:
- loads 1 on every rising edge;
- otherwise increments by 1 each cycle;
- saturates at all-ones and never wraps.
REQ-018 HIGH state:
- on a falling edge, the counter value SHALL be captured into an internal high register and the FSM SHALL go to LOW;
- on a rising edge, the FSM SHALL stay in HIGH.
REQ-019 LOW state, on a rising edge:
- o_period <= counter value and o_high <= captured high value;
- o_valid <= 1;
- the FSM SHALL go to HIGH.
REQ-020 Measurement latency: o_valid SHALL be seen high after the 3rd i_clk rising edge, counting the edge that first samples i_pwm=1.
REQ-021 o_period and o_high SHALL change only when a measurement completes, and SHALL hold otherwise.
REQ-022 o_valid SHALL clear on i_ack only when no measurement completes in the same cycle.
REQ-023 When a measurement completes while o_valid=1:
- without i_ack in the same cycle, the outputs SHALL be overwritten and o_overrun SHALL be set;
- with i_ack in the same cycle, the new data SHALL load, o_valid SHALL stay 1 and o_overrun SHALL be unchanged.
REQ-024 o_overrun SHALL clear on i_clr; if i_clr and a new overrun occur in the same cycle, set SHALL win.
REQ-025 Stuck detection:
- the idle counter SHALL restart at 0 on any edge;
- in any non-STUCK state with i_timeout!=0, when the idle counter reaches i_timeout, the FSM SHALL enter STUCK;
- on that entry, o_stuck <= 1 and o_level <= sync level.
REQ-026 STUCK SHALL exit to HIGH on a rising edge:
- o_stuck <= 0;
- no measurement is produced on that edge;
- falling edges in STUCK SHALL be ignored.
REQ-027 A change of i_timeout SHALL take effect immediately, and a value at or below the current idle count SHALL trigger STUCK on the next cycle.
REQ-028 o_period and o_high SHALL be unsigned; a saturated value SHALL mean the true value is at least 2^W-1.

Reset
REQ-029 On i_rst_n=0, the block SHALL asynchronously set:
- o_period=0, o_high=0;
- o_valid=0, o_overrun=0, o_stuck=0, o_level=0;
- synchronizer flops=0, all counters=0, FSM=ARM.
REQ-030 Reset asserted mid-measurement SHALL discard the partial counts, and after release the first rising edge SHALL only re-arm.

Verification
REQ-031 Periodic waveform:
- stimulus: i_pwm with period 10 clocks, high 3, 4 periods, no i_ack;
- response: the first rising edge gives no valid; then o_period=10, o_high=3, o_valid=1;
- o_overrun=1 after the 2nd completed measurement.
REQ-032 Ack handling:
- stimulus: i_ack pulsed one cycle after each o_valid, period 7 clocks, high 5;
- response: o_period=7, o_high=5, o_overrun stays 0.
REQ-033 Simultaneous ack and new data:
- stimulus: i_ack asserted in the same cycle a measurement completes;
- response: o_valid stays 1, new values load, o_overrun unchanged.
REQ-034 Stuck high:
- stimulus: i_timeout=20, i_pwm held 1 after a rising edge;
- response: o_stuck=1 and o_level=1 within 20+3 cycles of the edge;
- the next rising edge clears o_stuck with no o_valid;
- the following period measures correctly.
REQ-035 Reset mid-measurement:
- stimulus: i_rst_n pulsed low during a high phase;
- response: all outputs 0 immediately (asynchronously);
- the first measurement after release appears on the 2nd rising edge.
REQ-036 Saturation:
- stimulus: W=8, i_timeout=0, period 300 clocks;
- response: o_period=255 and o_high saturate at 255 without wrapping.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM measurement block and its consumer.
// The slave side is the capture block; the master side drives the waveform,
// the timeout limit and the acknowledge/clear strobes.
interface pwm_capture_if #(
    parameter int W = 32
);
    logic         i_pwm;
    logic [W-1:0] i_timeout;
    logic         i_ack;
    logic         i_clr;
    logic [W-1:0] o_period;
    logic [W-1:0] o_high;
    logic         o_valid;
    logic         o_overrun;
    logic         o_stuck;
    logic         o_level;

    modport master (
        output i_pwm, i_timeout, i_ack, i_clr,
        input  o_period, o_high, o_valid, o_overrun, o_stuck, o_level
    );

    modport slave (
        input  i_pwm, i_timeout, i_ack, i_clr,
        output o_period, o_high, o_valid, o_overrun, o_stuck, o_level
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM period / high-time capture.
// The asynchronous PWM line is synchronized, its edges drive a four-state
// FSM (ARM, HIGH, LOW, STUCK), and completed measurements are held in an
// output register with a valid/ack handshake and a sticky overrun flag.
// A separate idle counter flags a line that stops toggling.
module pwm_capture #(
    parameter int W = 32
) (
    input logic           i_clk,
    input logic           i_rst_n,
    pwm_capture_if.slave  bus
);
    typedef enum logic [1:0] {
        ARM   = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } state_t;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        sat_inc = (&v) ? v : v + ONE;
    endfunction

    logic         sync_p0;
    logic         sync_p1;
    logic         prev_p2;
    logic         rise;
    logic         fall;
    logic         any_edge;
    logic         timeout_hit;

    logic [W-1:0] cnt_q;
    logic [W-1:0] idle_q;
    logic [W-1:0] high_q;

    state_t       state_q;
    state_t       state_d;
    logic         meas_done;
    logic         cap_high;
    logic         enter_stuck;
    logic         exit_stuck;
    logic         ovr_set;

    logic [W-1:0] period_q;
    logic [W-1:0] high_out_q;
    logic         valid_q;
    logic         overrun_q;
    logic         stuck_q;
    logic         level_q;

    // Stage p0/p1: metastability synchronizer; stage p2: previous level for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= bus.i_pwm;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise        = sync_p1 & ~prev_p2;
    assign fall        = ~sync_p1 & prev_p2;
    assign any_edge    = rise | fall;
    // A timeout at or below the current idle count fires at once, so a
    // lowered limit takes effect on the next cycle.
    assign timeout_hit = (bus.i_timeout != '0) && (idle_q >= bus.i_timeout);

    // Edge counter: restarts at 1 on every rising edge, saturating count otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= rise ? ONE : sat_inc(cnt_q);
        end
    end

    // Idle counter: cycles since the last edge of either polarity.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= any_edge ? '0 : sat_inc(idle_q);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and single-cycle action strobes.
    always_comb begin
        state_d     = state_q;
        meas_done   = 1'b0;
        cap_high    = 1'b0;
        enter_stuck = 1'b0;
        exit_stuck  = 1'b0;
        unique case (state_q)
            ARM: begin
                if (rise) state_d = HIGH;
            end
            HIGH: begin
                if (fall) begin
                    cap_high = 1'b1;
                    state_d  = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    meas_done = 1'b1;
                    state_d   = HIGH;
                end
            end
            STUCK: begin
                if (rise) begin
                    exit_stuck = 1'b1;
                    state_d    = HIGH;
                end
            end
        endcase
        // A live edge in the same cycle counts as activity, so it wins over the timeout.
        if ((state_q != STUCK) && timeout_hit && !any_edge) begin
            state_d     = STUCK;
            enter_stuck = 1'b1;
        end
    end

    // High-time capture on the falling edge of a measured pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            high_q <= '0;
        end else if (cap_high) begin
            high_q <= cnt_q;
        end
    end

    // An unacknowledged result being replaced sets overrun, unless acked in the same cycle.
    assign ovr_set = meas_done & valid_q & ~bus.i_ack;

    // Result registers with valid/ack handshake and sticky overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            period_q   <= '0;
            high_out_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (meas_done) begin
                period_q   <= cnt_q;
                high_out_q <= high_q;
                valid_q    <= 1'b1;
            end else if (bus.i_ack) begin
                valid_q    <= 1'b0;
            end
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (bus.i_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Stuck indication and the line level frozen at the moment it went stuck.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stuck_q <= 1'b0;
            level_q <= 1'b0;
        end else if (enter_stuck) begin
            stuck_q <= 1'b1;
            level_q <= sync_p1;
        end else if (exit_stuck) begin
            stuck_q <= 1'b0;
        end
    end

    assign bus.o_period  = period_q;
    assign bus.o_high    = high_out_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_overrun = overrun_q;
    assign bus.o_stuck   = stuck_q;
    assign bus.o_level   = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a 32-bit instance checked against a timestamp-based
// reference model, plus an 8-bit instance sharing the stimulus for saturation.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm = 1'b0;
    logic        ack = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] timeout = 32'd0;

    always #5 clk = ~clk;

    pwm_capture_if #(.W(32)) if32 ();
    pwm_capture_if #(.W(8))  if8 ();

    assign if32.i_pwm     = pwm;
    assign if32.i_ack     = ack;
    assign if32.i_clr     = clr;
    assign if32.i_timeout = timeout;
    assign if8.i_pwm      = pwm;
    assign if8.i_ack      = ack;
    assign if8.i_clr      = clr;
    assign if8.i_timeout  = 8'd0;

    pwm_capture #(.W(32)) dut   (.i_clk(clk), .i_rst_n(rst_n), .bus(if32));
    pwm_capture #(.W(8))  dut8  (.i_clk(clk), .i_rst_n(rst_n), .bus(if8));

    int checks = 0;
    int errors = 0;
    int nprint = 0;
    bit model_on = 1'b0;

    // Reference model: edge timestamps on the line as seen two clocks late.
    bit          lvl[$];
    longint      m_k;
    longint      m_t_rise;
    longint      m_t_fall;
    bit          m_have_rise;
    bit          m_have_fall;
    logic [31:0] m_period;
    logic [31:0] m_high;
    bit          m_valid;
    bit          m_ovr;

    function automatic logic [31:0] sat32(input longint x);
        if (x > 64'sd4294967295) return 32'hFFFF_FFFF;
        return 32'(x);
    endfunction

    task automatic model_reset();
        lvl.delete();
        for (int i = 0; i < 3; i++) lvl.push_front(1'b0);
        m_k = 0; m_t_rise = 0; m_t_fall = 0;
        m_have_rise = 0; m_have_fall = 0;
        m_period = '0; m_high = '0; m_valid = 0; m_ovr = 0;
    endtask

    task automatic model_step(input bit p, input bit a, input bit c);
        bit r, f, done, set;
        logic [31:0] np, nh;
        m_k++;
        lvl.push_front(p);
        while (lvl.size() > 4) void'(lvl.pop_back());
        r = lvl[2] && !lvl[3];
        f = !lvl[2] && lvl[3];
        done = 0; set = 0; np = '0; nh = '0;
        if (f && m_have_rise) begin
            m_t_fall = m_k;
            m_have_fall = 1;
        end
        if (r) begin
            if (m_have_rise && m_have_fall) begin
                done = 1;
                np = sat32(m_k - m_t_rise);
                nh = sat32(m_t_fall - m_t_rise);
            end
            m_have_rise = 1;
            m_have_fall = 0;
            m_t_rise = m_k;
        end
        if (done) begin
            set = m_valid && !a;
            m_period = np;
            m_high = nh;
            m_valid = 1;
        end else if (a) begin
            m_valid = 0;
        end
        if (set) m_ovr = 1;
        else if (c) m_ovr = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: model advances with the inputs that the DUT sampled.
    task automatic tick();
        @(posedge clk);
        model_step(pwm, ack, clr);
        @(negedge clk);
        if (model_on) begin
            checks++;
            if (if32.o_period !== m_period || if32.o_high !== m_high ||
                if32.o_valid !== m_valid || if32.o_overrun !== m_ovr || if32.o_stuck !== 1'b0) begin
                errors++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL model t=%0t: period %0d/%0d high %0d/%0d valid %0b/%0b ovr %0b/%0b stuck %0b/0 (got/expected)",
                             $time, if32.o_period, m_period, if32.o_high, m_high,
                             if32.o_valid, m_valid, if32.o_overrun, m_ovr, if32.o_stuck);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pwm = 1'b0; ack = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_wave(input int per, input int hi, input int n, input bit ack_mode);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < per; c++) begin
                pwm = (c < hi);
                tick();
                if (ack_mode) ack = if32.o_valid;
            end
        end
        pwm = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (ack_mode) ack = if32.o_valid;
        end
        ack = 1'b0;
    endtask

    typedef struct {
        int          per;
        int          hi;
        int          n;
        bit          ack_mode;
        logic [31:0] e_per;
        logic [31:0] e_hi;
        bit          e_val;
        bit          e_ovr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int hit_n;
        bit found;

        vecs[0] = '{10,  3, 4, 1'b0, 32'd10, 32'd3,  1'b1, 1'b1};
        vecs[1] = '{ 7,  5, 4, 1'b1, 32'd7,  32'd5,  1'b0, 1'b0};
        vecs[2] = '{ 2,  1, 5, 1'b0, 32'd2,  32'd1,  1'b1, 1'b1};
        vecs[3] = '{ 3,  2, 3, 1'b1, 32'd3,  32'd2,  1'b0, 1'b0};
        vecs[4] = '{10,  3, 1, 1'b0, 32'd10, 32'd3,  1'b1, 1'b0};
        vecs[5] = '{15,  1, 2, 1'b1, 32'd15, 32'd1,  1'b0, 1'b0};
        vecs[6] = '{25, 24, 2, 1'b0, 32'd25, 32'd24, 1'b1, 1'b1};

        // Reset values while reset is held.
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_period",  if32.o_period, 32'd0);
        check("rst_high",    if32.o_high, 32'd0);
        check("rst_valid",   32'(if32.o_valid), 32'd0);
        check("rst_overrun", 32'(if32.o_overrun), 32'd0);
        check("rst_stuck",   32'(if32.o_stuck), 32'd0);
        check("rst_level",   32'(if32.o_level), 32'd0);
        rst_n = 1'b1;

        // Table-driven waveforms.
        model_on = 1'b1;
        foreach (vecs[i]) begin
            do_reset();
            run_wave(vecs[i].per, vecs[i].hi, vecs[i].n, vecs[i].ack_mode);
            check($sformatf("vec%0d_period", i),  if32.o_period, vecs[i].e_per);
            check($sformatf("vec%0d_high", i),    if32.o_high, vecs[i].e_hi);
            check($sformatf("vec%0d_valid", i),   32'(if32.o_valid), 32'(vecs[i].e_val));
            check($sformatf("vec%0d_overrun", i), 32'(if32.o_overrun), 32'(vecs[i].e_ovr));
        end

        // Latency, simultaneous ack with new data, overrun set beats clear.
        do_reset();
        pwm = 1'b1; repeat (3) tick();
        pwm = 1'b0; repeat (3) tick();
        pwm = 1'b1;
        tick(); check("lat_edge1_valid", 32'(if32.o_valid), 32'd0);
        tick(); check("lat_edge2_valid", 32'(if32.o_valid), 32'd0);
        tick(); check("lat_edge3_valid", 32'(if32.o_valid), 32'd1);
        check("lat_period", if32.o_period, 32'd6);
        repeat (2) tick();
        pwm = 1'b0; repeat (3) tick();
        pwm = 1'b1; repeat (2) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        check("simack_valid",   32'(if32.o_valid), 32'd1);
        check("simack_period",  if32.o_period, 32'd8);
        check("simack_high",    if32.o_high, 32'd5);
        check("simack_overrun", 32'(if32.o_overrun), 32'd0);
        repeat (2) tick();
        pwm = 1'b0; repeat (4) tick();
        pwm = 1'b1; repeat (2) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        check("setwins_overrun", 32'(if32.o_overrun), 32'd1);
        check("setwins_period",  if32.o_period, 32'd9);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_overrun", 32'(if32.o_overrun), 32'd0);
        ack = 1'b1; tick(); ack = 1'b0;
        check("ack_clears_valid", 32'(if32.o_valid), 32'd0);

        // Reset during a high phase.
        do_reset();
        pwm = 1'b1; repeat (3) tick();
        pwm = 1'b0; repeat (3) tick();
        pwm = 1'b1; repeat (3) tick();
        check("pre_rst_valid", 32'(if32.o_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_period", if32.o_period, 32'd0);
        check("async_rst_high",   if32.o_high, 32'd0);
        check("async_rst_valid",  32'(if32.o_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) tick();
        check("rearm_no_valid", 32'(if32.o_valid), 32'd0);
        pwm = 1'b0; repeat (6) tick();
        pwm = 1'b1; repeat (3) tick();
        check("post_rst_valid",  32'(if32.o_valid), 32'd1);
        check("post_rst_period", if32.o_period, 32'd10);
        check("post_rst_high",   if32.o_high, 32'd4);

        // Saturation on the 8-bit instance; the 32-bit one still measures exactly.
        do_reset();
        run_wave(300, 270, 2, 1'b0);
        check("sat8_period", 32'(if8.o_period), 32'd255);
        check("sat8_high",   32'(if8.o_high), 32'd255);
        check("sat8_valid",  32'(if8.o_valid), 32'd1);
        check("w32_period",  if32.o_period, 32'd300);
        check("w32_high",    if32.o_high, 32'd270);

        // Stuck-high detection and recovery.
        model_on = 1'b0;
        timeout = 32'd20;
        do_reset();
        pwm = 1'b1;
        found = 1'b0; hit_n = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (!found && if32.o_stuck) begin
                found = 1'b1;
                hit_n = n;
            end
        end
        check("stuck_found", 32'(found), 32'd1);
        check("stuck_in_window", 32'(hit_n >= 21 && hit_n <= 24), 32'd1);
        check("stuck_level", 32'(if32.o_level), 32'd1);
        pwm = 1'b0; repeat (3) tick();
        check("stuck_ignores_fall", 32'(if32.o_stuck), 32'd1);
        pwm = 1'b1; repeat (3) tick();
        check("stuck_exit", 32'(if32.o_stuck), 32'd0);
        check("stuck_exit_no_valid", 32'(if32.o_valid), 32'd0);
        repeat (3) tick();
        pwm = 1'b0; repeat (4) tick();
        pwm = 1'b1; repeat (3) tick();
        check("after_stuck_valid",  32'(if32.o_valid), 32'd1);
        check("after_stuck_period", if32.o_period, 32'd10);
        check("after_stuck_high",   if32.o_high, 32'd6);
        repeat (10) tick();
        check("no_stuck_below_limit", 32'(if32.o_stuck), 32'd0);
        timeout = 32'd5;
        tick();
        check("timeout_lowered_stuck", 32'(if32.o_stuck), 32'd1);
        check("timeout_lowered_level", 32'(if32.o_level), 32'd1);
        timeout = 32'd0;

        // Randomized waveforms, ack and clear against the model.
        model_on = 1'b1;
        do_reset();
        for (int p = 0; p < 40; p++) begin
            int per, hi;
            per = $urandom_range(40, 2);
            hi  = $urandom_range(per - 1, 1);
            for (int c = 0; c < per; c++) begin
                pwm = (c < hi);
                ack = ($urandom_range(3, 0) == 0);
                clr = ($urandom_range(7, 0) == 0);
                tick();
            end
        end
        ack = 1'b0; clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
